// File: rtl/sram_resp.sv
// Single-port word SRAM behind a valid/ready request/response handshake, one access in flight.
// Optional SRAM_LFSR_DELAY_EN: per-request wait cycles come from an 8-bit LFSR instead of LATENCY.
module sram_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [29:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [3:0]  dly;

    logic [31:0] mem [DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

`ifdef SRAM_LFSR_DELAY_EN
    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting toward the MSB
    logic [7:0] lfsr_q, lfsr_d;

    always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end

    assign dly = lfsr_q[3:0];
`else
    assign dly = 4'(LATENCY);
`endif

    // Zero-delay requests hit the array on the accept edge with live inputs;
    // delayed ones use the latched copy when the countdown expires.
    logic          acc_go, acc_wen, acc_oor;
    logic [29:0]   acc_idx;
    logic [31:0]   acc_wdata, acc_old;
    logic [3:0]    acc_wmask;
    logic [AW-1:0] acc_widx;

    always_comb begin
        acc_go    = 1'b0;
        acc_wen   = wen_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_wmask = wmask_q;
        if (state_q == IDLE && req_valid && dly == 4'd0) begin
            acc_go    = 1'b1;
            acc_wen   = req_wen;
            acc_idx   = req_addr[31:2];
            acc_wdata = req_wdata;
            acc_wmask = req_wmask;
        end else if (state_q == WAIT && cnt_q == 4'd0) begin
            acc_go = 1'b1;
        end
    end

    assign acc_oor  = (acc_idx >= 30'(DEPTH));
    assign acc_widx = acc_idx[AW-1:0];
    assign acc_old  = mem[acc_widx];

    always_ff @(posedge clk) begin
        if (rst_n && acc_go && acc_wen && !acc_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wmask[i]) mem[acc_widx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    idx_d   = req_addr[31:2];
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    if (dly == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = dly - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (acc_go) begin
            rdata_d = (acc_wen || acc_oor) ? 32'h0 : acc_old;
            err_d   = acc_oor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            idx_q   <= 30'd0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_sram_resp.sv
// Bench for sram_resp: three instances (LATENCY 1, 0, 3) driven through a shared
// transaction task; expected responses go through a queue scoreboard.
module tb_sram_resp;
    localparam int N     = 3;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      [N];
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic        req_wen    [N];
    logic [31:0] req_addr   [N];
    logic [31:0] req_wdata  [N];
    logic [3:0]  req_wmask  [N];
    logic        resp_valid [N];
    logic        resp_ready [N];
    logic [31:0] resp_rdata [N];
    logic        resp_err   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sram_resp #(
            .DEPTH  (DEPTH),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wen   (req_wen[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wmask (req_wmask[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

`ifdef SRAM_LFSR_DELAY_EN
    logic [7:0] m_lfsr [N];
    always @(posedge clk) begin
        for (int k = 0; k < N; k++)
            m_lfsr[k] <= !rst_n[k] ? 8'hA5
                       : {m_lfsr[k][6:0], m_lfsr[k][7] ^ m_lfsr[k][5] ^ m_lfsr[k][4] ^ m_lfsr[k][3]};
    end
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] ref_mem [int];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic exp_t model(input int k, input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] mask, input int d);
        exp_t        e;
        logic [29:0] idx;
        logic [31:0] w;
        int          key;
        idx     = addr[31:2];
        e.lat   = d + 1;
        e.err   = (idx >= 30'(DEPTH));
        e.rdata = 32'h0;
        key     = k * 4096 + int'(idx[11:0]);
        if (!e.err) begin
            w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
            if (wen) begin
                for (int i = 0; i < 4; i++)
                    if (mask[i]) w[8*i +: 8] = wdata[8*i +: 8];
                ref_mem[key] = w;
            end else begin
                e.rdata = w;
            end
        end
        return e;
    endfunction

    // Called at a negedge with the instance idle; returns at the negedge after the handshake.
    task automatic txn(input int k, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int hold, input string tag);
        exp_t e;
        int   d, c;
        bit   bad;
        req_valid[k] = 1'b1;
        req_wen[k]   = wen;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_wmask[k] = mask;
        chk({tag, ":ready"}, 64'(req_ready[k]), 64'd1);
`ifdef SRAM_LFSR_DELAY_EN
        d = int'(m_lfsr[k][3:0]);
`else
        d = lat_of(k);
`endif
        sb_q.push_back(model(k, wen, addr, wdata, mask, d));
        @(negedge clk);
        // Junk store offered while busy must be ignored.
        req_wen[k]   = 1'b1;
        req_addr[k]  = 32'h0000_03FC;
        req_wdata[k] = 32'hFFFF_FFFF;
        req_wmask[k] = 4'hF;
        c   = 1;
        bad = 1'b0;
        while (!resp_valid[k] && c < 40) begin
            if (req_ready[k]) bad = 1'b1;
            @(negedge clk);
            c++;
        end
        e = sb_q.pop_front();
        chk({tag, ":lat"}, 64'(c), 64'(e.lat));
        chk({tag, ":rdata"}, 64'(resp_rdata[k]), 64'(e.rdata));
        chk({tag, ":err"}, 64'(resp_err[k]), 64'(e.err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!resp_valid[k] || resp_rdata[k] !== e.rdata || resp_err[k] !== e.err) bad = 1'b1;
            if (req_ready[k]) bad = 1'b1;
        end
        chk({tag, ":busy_stable"}, 64'(bad), 64'd0);
        resp_ready[k] = 1'b1;
        req_valid[k]  = 1'b0;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        chk({tag, ":ready_after"}, 64'(req_ready[k]), 64'd1);
        chk({tag, ":valid_after"}, 64'(resp_valid[k]), 64'd0);
    endtask

    initial begin
        bit          seen;
        logic        wen;
        logic [31:0] addr;
        int          sel;
        for (int k = 0; k < N; k++) begin
            rst_n[k]      = 1'b0;
            req_valid[k]  = 1'b0;
            req_wen[k]    = 1'b0;
            req_addr[k]   = 32'h0;
            req_wdata[k]  = 32'h0;
            req_wmask[k]  = 4'h0;
            resp_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst:req_ready", 64'(req_ready[k]), 64'd1);
            chk("rst:resp_valid", 64'(resp_valid[k]), 64'd0);
            chk("rst:rdata", 64'(resp_rdata[k]), 64'd0);
            chk("rst:err", 64'(resp_err[k]), 64'd0);
            rst_n[k] = 1'b1;
        end
        @(negedge clk);

        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "st10");
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, "ld10");

        txn(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, "st20");
        txn(0, 1'b1, 32'h20, 32'h0000_AB00, 4'b0010, 0, "pst20");
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, "ld20");

        txn(1, 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 0, "st8");
        txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 5, "ld8_hold");

        txn(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 0, "st0");
        txn(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 0, "ld_oor");
        txn(0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, "st_oor");
        txn(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 0, "st_oor_hi");
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, "ld0");
        txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, "ld13");

`ifndef SRAM_LFSR_DELAY_EN
        txn(2, 1'b1, 32'h40, 32'h55AA_55AA, 4'hF, 0, "st40");
        req_valid[2] = 1'b1;
        req_wen[2]   = 1'b1;
        req_addr[2]  = 32'h40;
        req_wdata[2] = 32'h1234_5678;
        req_wmask[2] = 4'hF;
        chk("abort:ready", 64'(req_ready[2]), 64'd1);
        @(negedge clk);
        req_valid[2] = 1'b0;
        rst_n[2]     = 1'b0;
        #1;
        chk("abort:rst_valid", 64'(resp_valid[2]), 64'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        seen     = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid[2]) seen = 1'b1;
        end
        chk("abort:no_resp", 64'(seen), 64'd0);
        chk("abort:ready_idle", 64'(req_ready[2]), 64'd1);
        txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 0, "ld40_after_abort");
`endif

        for (int i = 0; i < 8; i++)
            txn(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 0, "rnd_init");
        for (int i = 0; i < 50; i++) begin
            wen  = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 8);
            addr = (sel == 8) ? 32'h0000_2000 + 32'(4 * $urandom_range(0, 255))
                              : 32'h100 + 32'(4 * sel);
            addr = addr | 32'($urandom_range(0, 3));
            txn(0, wen, addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
